// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array controller.
// Holds the controller state enum and a saturating 32-bit increment helper.
package systolic_pkg;
  localparam int SYS_N_DEF  = 4;
  localparam int SYS_KW_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/systolic_ctrl_if.sv
// Result-drain handshake between the controller (master) and the row consumer (slave).
// The master presents a row index with valid; the slave accepts it with ready.
interface systolic_ctrl_if
  import systolic_pkg::*;
  #(parameter int N = SYS_N_DEF) ();
  logic                 o_drain_valid;
  logic                 i_drain_ready;
  logic [$clog2(N)-1:0] o_drain_row;

  modport master (output o_drain_valid, output o_drain_row, input i_drain_ready);
  modport slave  (input o_drain_valid, input o_drain_row, output i_drain_ready);
endinterface

// File: rtl/systolic_skew_gen.sv
// Diagonal operand-enable generator: row/column i is live while i <= t < i+K.
// Purely combinational; the controller registers the result.
module systolic_skew_gen
  import systolic_pkg::*;
  #(
    parameter int N  = SYS_N_DEF,
    parameter int KW = SYS_KW_DEF,
    parameter int CW = KW + $clog2(N)
  ) (
    input  logic          i_feed,
    input  logic [CW-1:0] i_t,
    input  logic [KW-1:0] i_k,
    output logic [N-1:0]  o_en
  );

  // One extra bit so i+K never wraps at the maximum K.
  logic [CW:0] w_t;
  assign w_t = {1'b0, i_t};

  always_comb begin
    o_en = '0;
    for (int i = 0; i < N; i++) begin
      if (i_feed && (w_t >= (CW+1)'(i)) && (w_t < ((CW+1)'(i) + (CW+1)'(i_k))))
        o_en[i] = 1'b1;
    end
  end
endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN systolic MAC array: clear, skewed feed, flush, drain rows, done.
// Optional busy-cycle counter on o_cycle_cnt when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_ctrl
  import systolic_pkg::*;
  #(
    parameter int N  = SYS_N_DEF,
    parameter int KW = SYS_KW_DEF
  ) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [KW-1:0]             i_k_len,
    output logic                      o_busy,
    output logic                      o_arr_clr,
    output logic [KW+$clog2(N)-1:0]   o_feed_t,
    output logic [N-1:0]              o_row_en,
    output logic [N-1:0]              o_col_en,
    output logic                      o_done,
`ifdef SYSTOLIC_CTRL_PERF_EN
    output logic [31:0]               o_cycle_cnt,
`endif
    systolic_ctrl_if.master           drain
  );

  localparam int CW = KW + $clog2(N);
  localparam int RW = $clog2(N);

  state_t        r_state, w_state_nxt;
  logic [KW-1:0] r_k;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_feed_last, w_feed_t_nxt;
  logic [RW-1:0] r_row, w_row_nxt;
  logic [N-1:0]  w_en;

  logic          r_busy, r_arr_clr, r_done, r_drain_vld;
  logic [CW-1:0] r_feed_t;
  logic [N-1:0]  r_row_en, r_col_en;
  logic [RW-1:0] r_drain_row;

  // Last feed index is F-1 = K+N-2; only evaluated when K >= 1.
  assign w_feed_last = CW'(r_k) + CW'(N) - CW'(2);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
          w_row_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_cnt_nxt   = '0;
        w_state_nxt = (r_k == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        if (r_cnt == w_feed_last) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_FLUSH: begin
        if (r_cnt == CW'(N - 1)) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (r_drain_vld && drain.i_drain_ready) begin
          if (r_row == RW'(N - 1)) begin
            w_state_nxt = S_DONE;
            w_row_nxt   = '0;
          end else begin
            w_row_nxt = r_row + RW'(1);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_feed_t_nxt = (w_state_nxt == S_FEED) ? w_cnt_nxt : '0;

  systolic_skew_gen #(.N(N), .KW(KW), .CW(CW)) u_skew (
    .i_feed (w_state_nxt == S_FEED),
    .i_t    (w_feed_t_nxt),
    .i_k    (r_k),
    .o_en   (w_en)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_cnt       <= '0;
      r_row       <= '0;
      r_busy      <= 1'b0;
      r_arr_clr   <= 1'b0;
      r_feed_t    <= '0;
      r_row_en    <= '0;
      r_col_en    <= '0;
      r_drain_vld <= 1'b0;
      r_drain_row <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_row       <= w_row_nxt;
      if (r_state == S_IDLE && i_start)
        r_k <= i_k_len;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_arr_clr   <= (w_state_nxt == S_CLEAR);
      r_feed_t    <= w_feed_t_nxt;
      r_row_en    <= w_en;
      r_col_en    <= w_en;
      r_drain_vld <= (w_state_nxt == S_DRAIN);
      r_drain_row <= (w_state_nxt == S_DRAIN) ? w_row_nxt : '0;
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign o_busy              = r_busy;
  assign o_arr_clr           = r_arr_clr;
  assign o_feed_t            = r_feed_t;
  assign o_row_en            = r_row_en;
  assign o_col_en            = r_col_en;
  assign o_done              = r_done;
  assign drain.o_drain_valid = r_drain_vld;
  assign drain.o_drain_row   = r_drain_row;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] r_run_cnt, r_cycle_cnt;

  // r_run_cnt tracks the cycle count as of the state being entered, so DONE publishes the total.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run_cnt   <= '0;
      r_cycle_cnt <= '0;
    end else begin
      if (w_state_nxt == S_CLEAR)
        r_run_cnt <= 32'd1;
      else if (w_state_nxt != S_IDLE)
        r_run_cnt <= sat_inc32(r_run_cnt);
      if (w_state_nxt == S_DONE)
        r_cycle_cnt <= sat_inc32(r_run_cnt);
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (N=4, KW=8): timing, skew, stall, K=0, reset abort, start-ignore.
module tb_systolic_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  k_len;
  logic        busy, clr, done;
  logic [9:0]  feed_t;
  logic [3:0]  row_en, col_en;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] cyc_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  systolic_ctrl_if #(.N(4)) dif ();

  systolic_ctrl #(.N(4), .KW(8)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_k_len   (k_len),
    .o_busy    (busy),
    .o_arr_clr (clr),
    .o_feed_t  (feed_t),
    .o_row_en  (row_en),
    .o_col_en  (col_en),
    .o_done    (done),
`ifdef SYSTOLIC_CTRL_PERF_EN
    .o_cycle_cnt (cyc_cnt),
`endif
    .drain     (dif.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_en(input int t, input int k);
    logic [3:0] e;
    logic [3:0] k3_tab [6];
    k3_tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    e = '0;
    if (k == 3 && t < 6) begin
      e = k3_tab[t];
    end else begin
      for (int i = 0; i < 4; i++)
        if (t >= i && t < i + k) e[i] = 1'b1;
    end
    return e;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"},  32'(busy),  32'd0);
    chk({tag, ".clr"},   32'(clr),   32'd0);
    chk({tag, ".feed_t"},32'(feed_t),32'd0);
    chk({tag, ".row_en"},32'(row_en),32'd0);
    chk({tag, ".col_en"},32'(col_en),32'd0);
    chk({tag, ".dvld"},  32'(dif.o_drain_valid), 32'd0);
    chk({tag, ".drow"},  32'(dif.o_drain_row),   32'd0);
    chk({tag, ".done"},  32'(done),  32'd0);
  endtask

  // One full operation from start pulse to return to IDLE, checking every cycle.
  task automatic run_op(input int k, input int stall_row, input int stall_n, input bit poke);
    int stalls;
    stalls = 0;
    k_len = 8'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clear.clr",  32'(clr),    32'd1);
    chk("clear.busy", 32'(busy),   32'd1);
    chk("clear.en",   32'(row_en), 32'd0);
    if (k > 0) begin
      for (int t = 0; t < k + 3; t++) begin
        tick();
        chk("feed.t",   32'(feed_t), 32'(t));
        chk("feed.row", 32'(row_en), 32'(exp_en(t, k)));
        chk("feed.col", 32'(col_en), 32'(exp_en(t, k)));
        chk("feed.clr", 32'(clr),    32'd0);
      end
      for (int j = 0; j < 4; j++) begin
        tick();
        chk("flush.en",   32'(row_en),            32'd0);
        chk("flush.dvld", 32'(dif.o_drain_valid), 32'd0);
        chk("flush.busy", 32'(busy),              32'd1);
        start = poke && (j == 1);
      end
      start = 1'b0;
    end
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("drain.dvld", 32'(dif.o_drain_valid), 32'd1);
      chk("drain.row",  32'(dif.o_drain_row),   32'(r));
      chk("drain.en",   32'(row_en),            32'd0);
      chk("drain.done", 32'(done),              32'd0);
      if (r == stall_row) begin
        dif.i_drain_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk("stall.dvld", 32'(dif.o_drain_valid), 32'd1);
          chk("stall.row",  32'(dif.o_drain_row),   32'(r));
          chk("stall.done", 32'(done),              32'd0);
          stalls++;
        end
        dif.i_drain_ready = 1'b1;
      end
    end
    tick();
    chk("done.pulse", 32'(done),              32'd1);
    chk("done.dvld",  32'(dif.o_drain_valid), 32'd0);
    chk("done.busy",  32'(busy),              32'd1);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("done.cyc", cyc_cnt, 32'(1 + ((k > 0) ? (k + 3 + 4) : 0) + 4 + stalls + 1));
`endif
    tick();
    chk("idle.done", 32'(done), 32'd0);
    chk("idle.busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    dif.i_drain_ready = 1'b1;
    repeat (3) tick();
    chk_reset_vals("rst");
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("rst.cyc", cyc_cnt, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Basic K=3 run: CLEAR 1, FEED 2-7, FLUSH 8-11, DRAIN 12-15, DONE 16.
    run_op(3, -1, 0, 1'b0);
    // Consumer stalls 5 cycles on row 2.
    run_op(3, 2, 5, 1'b0);
    // K=0 skips feed and flush entirely.
    run_op(0, -1, 0, 1'b0);
    // K=1 with a short stall on row 0.
    run_op(1, 0, 2, 1'b0);

    // Reset in FEED at t=2 aborts the operation.
    k_len = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("abort.t", 32'(feed_t), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("abort");
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("abort.cyc", cyc_cnt, 32'd0);
`endif
    tick();
    chk("abort.idle", 32'(busy), 32'd0);
    run_op(3, -1, 0, 1'b0);

    // Start pulsed during FLUSH must not launch a second operation.
    run_op(5, -1, 0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("poke.done", 32'(done), 32'd0);
      chk("poke.busy", 32'(busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, meaning the array dimension (NxN MAC cells).
REQ-002 SHALL have parameter KW, default 8, meaning the width of the reduction-length input.
REQ-003 SHALL have port i_clk  in  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst  in  1  meaning reset, which is synchronous and active-high.
REQ-005 SHALL have port i_start  in  1  meaning a request to begin one matrix multiply.
REQ-006 SHALL have port i_k_len  in  KW  meaning the reduction length K, sampled on start.
REQ-007 SHALL have port o_busy  out  1  meaning high in every state except IDLE.
REQ-008 SHALL have port o_arr_clr  out  1  meaning an active-high accumulator clear; the integrator inverts it to the array i_rst_n.
REQ-009 SHALL have port o_feed_t  out  KW+$clog2(N)  meaning the feed-cycle counter t.
REQ-010 SHALL have port o_row_en  out  N  meaning per-row A-operand valid; when a bit is low, the external mux drives 0.
REQ-011 SHALL have port o_col_en  out  N  meaning per-column B-operand valid, with the same zero rule as o_row_en.
REQ-012 SHALL have port o_drain_valid  out  1  meaning a result row is presented.
REQ-013 SHALL have port i_drain_ready  in  1  meaning the consumer accepts the presented row.
REQ-014 SHALL have port o_drain_row  out  $clog2(N)  meaning the index of the row presented.
REQ-015 SHALL have port o_done  out  1  meaning a one-cycle completion pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, CLEAR, FEED, FLUSH, DRAIN and DONE.
REQ-017 SHALL move from IDLE to CLEAR when i_start=1, latching i_k_len as K.
REQ-018 SHALL ignore i_start in every state other than IDLE.
REQ-019 SHALL stay in CLEAR for exactly 1 cycle with o_arr_clr=1, then go to FEED; if K=0 it SHALL go to DRAIN instead.
REQ-020 SHALL stay in FEED for F=K+N-1 cycles, with o_feed_t counting from 0 to F-1.
REQ-021 SHALL drive o_row_en[i]=o_col_en[i]=1 in FEED only when i<=t<i+K; the operand index for row i is then t-i.
REQ-022 SHALL drive o_row_en and o_col_en to all zeros outside FEED.
REQ-023 SHALL stay in FLUSH for exactly N cycles, so the last operands reach cell (N-1,N-1) and are accumulated.
REQ-024 SHALL run DRAIN as N beats with o_drain_row counting 0 to N-1; a beat completes when o_drain_valid and i_drain_ready are both 1.
REQ-025 SHALL hold o_drain_row and o_drain_valid stable while i_drain_ready=0.
REQ-026 SHALL go from DRAIN to DONE after beat N-1 completes; DONE SHALL last 1 cycle with o_done=1, then return to IDLE.
REQ-027 SHALL use a counter wide enough that F at K=2^KW-1 does not wrap.
REQ-028 SHALL produce all outputs from registers, with no combinational path from an input to an output.

Reset
REQ-029 SHALL, when i_rst=1 at a clock edge in any state, go to IDLE and clear every counter, aborting any operation in progress.
REQ-030 SHALL hold these values in reset: o_busy=0, o_arr_clr=0, o_feed_t=0, o_row_en=0, o_col_en=0, o_drain_valid=0, o_drain_row=0, o_done=0.

Configuration
REQ-031 SHALL, when SYSTOLIC_CTRL_PERF_EN is defined, add port o_cycle_cnt  out  32, holding the count of busy cycles in the last completed operation.
REQ-032 SHALL, with SYSTOLIC_CTRL_PERF_EN defined, count o_cycle_cnt from CLEAR through DONE inclusive, saturate it at 2^32-1, update it in DONE, and reset it to 0.
REQ-033 SHALL, when SYSTOLIC_CTRL_PERF_EN is undefined, omit o_cycle_cnt entirely with no other behavioural change.

Structure
REQ-034 SHALL place the state enum, the default N and the default KW in the shared package systolic_pkg.
REQ-035 SHALL use the sub-module systolic_skew_gen, which maps t, K and N to o_row_en and o_col_en combinationally before the output register.

Verification
REQ-036 SHALL cover: N=4, K=3, start at edge 0, ready held at 1 -> CLEAR in cycle 1, FEED in cycles 2-7, FLUSH in cycles 8-11, DRAIN in cycles 12-15, o_done=1 in cycle 16, and o_cycle_cnt=16 when PERF is enabled.
REQ-037 SHALL cover: N=4, K=3, feed cycle t=3 -> o_row_en=4'b1110 and o_col_en=4'b1110; at t=0 -> both 4'b0001.
REQ-038 SHALL cover: ready low for 5 cycles during drain row 2 -> o_drain_row held at 2 and o_drain_valid held at 1; o_done is delayed by 5 cycles.
REQ-039 SHALL cover: K=0 -> CLEAR followed directly by DRAIN, 4 beats, then o_done, with o_row_en=0 throughout.
REQ-040 SHALL cover: i_rst=1 in FEED at t=2 -> IDLE on the next cycle with all outputs at their reset values, and a following i_start runs a full operation normally.
REQ-041 SHALL cover: i_start pulsed in FLUSH -> ignored, with exactly one o_done pulse produced.
